vip_bit_morph_kxk: RTL and testbench
====================================

Name: vip_bit_morph_kxk

Overview:
- Parametrised binary morphology stage for the frame-difference motion pipeline; supersedes the fixed 7x7 erosion/dilation pair.
- Sits between the binarisation/threshold stage and the motion-box/statistics stage.
- Builds its own KxK window from internal line buffers and applies bypass, dilation (OR) or erosion (AND), selectable per frame.
- Out-of-image window positions take operation-neutral values, so image borders no longer bias the result.

Parameters:
IMG_HDISP, 640, active pixels per line (clken pulses per href)
IMG_VDISP, 480, active lines per frame
KSIZE, 7, window size; odd, legal range 3..7; elaborate-time error otherwise

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
morph_mode  in  2  00 bypass, 01 dilate, 10 erode, 11 treated as bypass; sampled per frame
per_frame_vsync  in  1  frame sync, active high, rising edge = frame start
per_frame_href  in  1  line valid, active high
per_frame_clken  in  1  pixel strobe, valid only while href high
per_img_Bit  in  1  input binary pixel
post_frame_vsync  out  1  vsync delayed 3 clk
post_frame_href  out  1  href delayed 3 clk
post_frame_clken  out  1  clken delayed 3 clk
post_img_Bit  out  1  processed pixel; 0 whenever post_frame_href is 0

Behaviour:
- Reset: all outputs 0, window/pipeline registers 0, counters 0, active mode = bypass. Line-buffer contents are not cleared; row masking makes stale data irrelevant.
- Mode latch: morph_mode is captured into active_mode on the clk after each vsync rising edge. Changes mid-frame take effect only at the next frame.
- Counters:
  - col_cnt increments on each clken and clears on href falling edge; it saturates at IMG_HDISP.
  - row_cnt increments on href falling edge and clears on vsync rising edge; it saturates at IMG_VDISP.
- Line buffers:
  - KSIZE-1 one-bit lines of IMG_HDISP entries, read and shifted at address col_cnt on clken.
  - Pixels with col_cnt >= IMG_HDISP are neither written nor shifted; their output is forced to 0.
- Window definition: causal. Output pixel (r,c) is computed over input rows r-KSIZE+1..r and columns c-KSIZE+1..c. Image content therefore shifts by (KSIZE-1)/2 right and down, consistent with the existing pipeline.
- Neutral fill: any window cell with row < 0 or column < 0 reads as 0 in dilate mode and 1 in erode mode.
- Pipeline, fixed 3 clk from input to output, independent of clken gaps:
  - Stage 1: window column shift registers update on clken; the window holds between strobes.
  - Stage 2: per-row reduction (OR or AND) over KSIZE bits.
  - Stage 3: reduction across rows, or centre-free bypass path = per_img_Bit delayed 3 clk.
- Sync signals: delayed through matching 3-stage shift registers. post_img_Bit = stage-3 result AND post_frame_href.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. After release, outputs stay 0 until href is seen. Correct results resume from the first full frame following a vsync rising edge.
- Frames shorter than IMG_VDISP lines or lines shorter than IMG_HDISP: no lock-up; counters resync on the next href/vsync edge.

Decomposition:
- Package vip_morph_pkg holds:
  - mode constants MORPH_BYPASS, MORPH_DILATE, MORPH_ERODE
  - KSIZE legality check
  - clog2-based counter width function
- One sub-module, vip_bit_line_buf: KSIZE-1 line FIFO bit buffer with clken-gated shift and tap outputs.
- Window, reduction and sync delay stay in the top level.

Test Plan:
- Config IMG_HDISP=16, IMG_VDISP=8, KSIZE=3, dilate. Single 1 at (3,5) -> output 1 exactly at rows 3..5, cols 5..7, 0 elsewhere; sync outputs equal inputs delayed 3 clk.
- Erode, all-ones frame -> all-ones output, including row 0/col 0 (neutral fill 1). Single 0 at (4,8) -> zeros exactly at rows 4..6, cols 8..10.
- Dilate with KSIZE=7, all-zero frame except a 1 at (0,0) -> ones at rows 0..6, cols 0..6; confirms no wrap-around from the previous line's end.
- morph_mode switches 01->10 mid-frame -> frame completes as dilate; next frame is eroded. Mode 11 -> output equals input delayed 3 clk.
- Gapped clken (random 50% duty within href) with the same image as the first scenario -> identical per-pixel results, latency still 3 clk.
- rst_n pulsed low mid-line -> all outputs 0 within the same cycle. The next full frame matches the golden model with no stale-buffer artefacts in rows 0..KSIZE-2.

Source files
------------

// File: rtl/vip_morph_pkg.sv
// Shared constants and elaboration helpers for the binary morphology stage.
// Holds no logic of its own, so it adds no latency and applies no backpressure.
package vip_morph_pkg;

  localparam logic [1:0] MORPH_BYPASS = 2'b00;
  localparam logic [1:0] MORPH_DILATE = 2'b01;
  localparam logic [1:0] MORPH_ERODE  = 2'b10;

  localparam int KSIZE_MIN = 3;
  localparam int KSIZE_MAX = 7;

  function automatic bit ksize_ok(input int k);
    return (k >= KSIZE_MIN) && (k <= KSIZE_MAX) && (k % 2 == 1);
  endfunction

  // Width that can hold 0..n inclusive, so counters can sit at their saturation value.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vip_bit_line_buf.sv
// Cascade of KSIZE-1 one-bit line memories; combinational tap read, write/shift on clken.
// Taps are valid in the same cycle as the address; there is no backpressure, since writes follow the pixel strobe.
module vip_bit_line_buf #(
  parameter int IMG_HDISP = 640,
  parameter int KSIZE     = 7,
  parameter int AW        = 10
) (
  input  logic             clk,
  input  logic             i_clken,
  input  logic [AW-1:0]    i_addr,
  input  logic             i_bit,
  output logic [KSIZE-2:0] o_taps
);

  localparam int NL = KSIZE - 1;
  localparam int IW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [AW-1:0] ADDR_END = AW'(IMG_HDISP);

  logic [IMG_HDISP-1:0] r_line [NL];
  logic                 w_in_range;
  logic [IW-1:0]        w_idx;

  assign w_in_range = (i_addr < ADDR_END);
  assign w_idx      = i_addr[IW-1:0];

  always_comb begin
    o_taps = '0;
    if (w_in_range) begin
      for (int k = 0; k < NL; k++) begin
        o_taps[k] = r_line[k][w_idx];
      end
    end
  end

  // Storage is deliberately left unreset; row masking upstream hides stale lines.
  always_ff @(posedge clk) begin
    if (i_clken && w_in_range) begin
      r_line[0][w_idx] <= i_bit;
      for (int k = 1; k < NL; k++) begin
        r_line[k][w_idx] <= r_line[k-1][w_idx];
      end
    end
  end

endmodule

// File: rtl/vip_bit_morph_kxk.sv
// KxK binary dilation/erosion/bypass over a causal window, with neutral fill outside the image.
// Fixed latency of 3 clk from input to output; no backpressure, the stage follows the pixel strobe.
module vip_bit_morph_kxk
  import vip_morph_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int KSIZE     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] morph_mode,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic       per_img_Bit,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_Bit
);

  localparam int CW = cnt_w(IMG_HDISP);
  localparam int RW = cnt_w(IMG_VDISP);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP);

  if (!ksize_ok(KSIZE)) begin : g_ksize_err
    $error("vip_bit_morph_kxk: KSIZE must be odd and within 3..7");
  end

  logic                r_vsync_d, r_href_d;
  logic [1:0]          r_mode;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [KSIZE-1:0]    r_win [KSIZE];
  logic [KSIZE-1:0]    r_red;
  logic [1:0]          r_byp;
  logic                r_s3;
  logic [2:0]          r_vs_sh, r_hr_sh, r_ck_sh;

  logic                w_vs_rise, w_href_fall, w_strobe;
  logic                w_erode, w_dilate, w_fill;
  logic [KSIZE-2:0]    w_taps;
  logic [KSIZE-1:0]    w_col;

  assign w_vs_rise   = per_frame_vsync & ~r_vsync_d;
  assign w_href_fall = ~per_frame_href & r_href_d;
  assign w_strobe    = per_frame_clken & per_frame_href;
  assign w_erode     = (r_mode == MORPH_ERODE);
  assign w_dilate    = (r_mode == MORPH_DILATE);
  assign w_fill      = w_erode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_mode    <= MORPH_BYPASS;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      r_vsync_d <= per_frame_vsync;
      r_href_d  <= per_frame_href;
      if (w_vs_rise) r_mode <= morph_mode;
      if (w_href_fall)                      r_col <= '0;
      else if (w_strobe && r_col != COL_MAX) r_col <= r_col + CW'(1);
      if (w_vs_rise)                             r_row <= '0;
      else if (w_href_fall && r_row != ROW_MAX)  r_row <= r_row + RW'(1);
    end
  end

  vip_bit_line_buf #(
    .IMG_HDISP(IMG_HDISP),
    .KSIZE    (KSIZE),
    .AW       (CW)
  ) u_line_buf (
    .clk    (clk),
    .i_clken(w_strobe),
    .i_addr (r_col),
    .i_bit  (per_img_Bit),
    .o_taps (w_taps)
  );

  // Entering column: row 0 is the live pixel, row j is j lines up, neutral above the image.
  always_comb begin
    w_col    = '0;
    w_col[0] = per_img_Bit;
    for (int j = 1; j < KSIZE; j++) begin
      w_col[j] = (r_row >= RW'(j)) ? w_taps[j-1] : w_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < KSIZE; j++) r_win[j] <= '0;
      r_red   <= '0;
      r_byp   <= '0;
      r_s3    <= 1'b0;
      r_vs_sh <= '0;
      r_hr_sh <= '0;
      r_ck_sh <= '0;
    end else begin
      // First pixel of a line flushes older columns to neutral instead of wrapping.
      if (w_strobe) begin
        for (int j = 0; j < KSIZE; j++) begin
          if (r_col == '0) r_win[j] <= {{(KSIZE-1){w_fill}}, w_col[j]};
          else             r_win[j] <= {r_win[j][KSIZE-2:0], w_col[j]};
        end
      end
      for (int j = 0; j < KSIZE; j++) begin
        r_red[j] <= w_erode ? (&r_win[j]) : (|r_win[j]);
      end
      r_byp <= {r_byp[0], per_img_Bit};
      if (w_erode)       r_s3 <= &r_red;
      else if (w_dilate) r_s3 <= |r_red;
      else               r_s3 <= r_byp[1];
      r_vs_sh <= {r_vs_sh[1:0], per_frame_vsync};
      r_hr_sh <= {r_hr_sh[1:0], per_frame_href};
      r_ck_sh <= {r_ck_sh[1:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = r_vs_sh[2];
  assign post_frame_href  = r_hr_sh[2];
  assign post_frame_clken = r_ck_sh[2];
  assign post_img_Bit     = r_s3 & r_hr_sh[2];

endmodule

// File: tb/tb_vip_bit_morph_kxk.sv
// Bench for vip_bit_morph_kxk: drives a K=3 and a K=7 instance with the same 16x8 frames
// and compares every captured output pixel against a direct window-reduction model.
module tb_vip_bit_morph_kxk;
  import vip_morph_pkg::*;

  localparam int H = 16;
  localparam int V = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] morph_mode;
  logic       vsync, href, clken, pbit;
  logic       vs3, hr3, ck3, bit3;
  logic       vs7, hr7, ck7, bit7;

  int   ncmp  = 0;
  int   nfail = 0;
  bit   img  [V][H];
  logic cap3 [V][H];
  logic cap7 [V][H];
  int   mrow = 0;
  int   mcol = 0;
  logic pvs  = 1'b0;
  logic phr  = 1'b0;
  logic [2:0] hq[$];
  bit   chk_sync = 1'b1;

  always #5 clk = ~clk;

  vip_bit_morph_kxk #(.IMG_HDISP(H), .IMG_VDISP(V), .KSIZE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .morph_mode(morph_mode),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(pbit),
    .post_frame_vsync(vs3), .post_frame_href(hr3), .post_frame_clken(ck3), .post_img_Bit(bit3)
  );

  vip_bit_morph_kxk #(.IMG_HDISP(H), .IMG_VDISP(V), .KSIZE(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .morph_mode(morph_mode),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Bit(pbit),
    .post_frame_vsync(vs7), .post_frame_href(hr7), .post_frame_clken(ck7), .post_img_Bit(bit7)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Output pixel = OR/AND over input rows r-k+1..r, cols c-k+1..c; outside cells are neutral.
  function automatic logic model(input int emode, input int k, input int r, input int c);
    logic acc, v, neutral;
    if (emode != 1 && emode != 2) return img[r][c];
    neutral = (emode == 2);
    acc     = neutral;
    for (int dr = 0; dr < k; dr++) begin
      for (int dc = 0; dc < k; dc++) begin
        v   = (r - dr < 0 || c - dc < 0) ? neutral : img[r-dr][c-dc];
        acc = (emode == 2) ? (acc & v) : (acc | v);
      end
    end
    return acc;
  endfunction

  // Sampled on the falling edge: sync outputs must be the inputs seen three samples earlier.
  task automatic monitor();
    logic [2:0] old;
    hq.push_back({vsync, href, clken});
    if (hq.size() == 4) begin
      old = hq.pop_front();
      if (chk_sync && rst_n) begin
        chk("vs_d3_k3", vs3, old[2]); chk("hr_d3_k3", hr3, old[1]); chk("ck_d3_k3", ck3, old[0]);
        chk("vs_d3_k7", vs7, old[2]); chk("hr_d3_k7", hr7, old[1]); chk("ck_d3_k7", ck7, old[0]);
      end
    end
    if (!hr3) chk("bit_hlow_k3", bit3, 1'b0);
    if (!hr7) chk("bit_hlow_k7", bit7, 1'b0);
    if (vs3 && !pvs) begin
      mrow = 0; mcol = 0;
    end else if (!hr3 && phr) begin
      mrow++; mcol = 0;
    end
    if (hr3 && ck3) begin
      if (mrow < V && mcol < H) begin
        cap3[mrow][mcol] = bit3;
        cap7[mrow][mcol] = bit7;
      end
      mcol++;
    end
    pvs = vs3;
    phr = hr3;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_vs3"}, vs3, 1'b0); chk({tag, "_hr3"}, hr3, 1'b0);
    chk({tag, "_ck3"}, ck3, 1'b0); chk({tag, "_bit3"}, bit3, 1'b0);
    chk({tag, "_vs7"}, vs7, 1'b0); chk({tag, "_hr7"}, hr7, 1'b0);
    chk({tag, "_ck7"}, ck7, 1'b0); chk({tag, "_bit7"}, bit7, 1'b0);
  endtask

  task automatic fill_img(input int pct_ones);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = ($urandom_range(0, 99) < pct_ones);
  endtask

  // mode < 0 leaves morph_mode untouched; sw_row switches it mid-frame; rst_row pulses reset mid-line.
  task automatic run_frame(input int mode, input bit gapped, input int sw_row,
                           input logic [1:0] sw_mode, input int rst_row);
    int c;
    bit did_rst;
    did_rst = 1'b0;
    if (mode >= 0) morph_mode = 2'(mode);
    for (int r = 0; r < V; r++)
      for (int cc = 0; cc < H; cc++) begin
        cap3[r][cc] = 1'bx;
        cap7[r][cc] = 1'bx;
      end
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; repeat (3) tick();
    for (int r = 0; r < V; r++) begin
      if (r == sw_row) morph_mode = sw_mode;
      href = 1'b1;
      c = 0;
      while (c < H) begin
        if (r == rst_row && c == H / 2 && !did_rst) begin
          did_rst  = 1'b1;
          chk_sync = 1'b0;
          chk("pre_rst_href_high", hr3, 1'b1);
          rst_n = 1'b0;
          #1;
          chk_outs_zero("rst_mid");
        end
        clken = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
        pbit  = clken ? img[r][c] : 1'($urandom_range(0, 1));
        tick();
        rst_n = 1'b1;
        if (clken) c++;
      end
      href = 1'b0; clken = 1'b0; pbit = 1'b0;
      repeat (4) tick();
    end
    repeat (6) tick();
    chk_sync = 1'b1;
  endtask

  task automatic check_frame(input int emode, input string tag);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        chk($sformatf("%s_k3_r%0dc%0d", tag, r, c), cap3[r][c], model(emode, 3, r, c));
        chk($sformatf("%s_k7_r%0dc%0d", tag, r, c), cap7[r][c], model(emode, 7, r, c));
      end
  endtask

  initial begin
    rst_n = 1'b0; morph_mode = MORPH_BYPASS;
    vsync = 1'b0; href = 1'b0; clken = 1'b0; pbit = 1'b0;
    repeat (3) tick();
    chk_outs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single 1 at (3,5), dilate.
    fill_img(0); img[3][5] = 1'b1;
    run_frame(1, 1'b0, -1, 2'b00, -1);
    check_frame(1, "dil_pt");
    chk("dil_pt_k3_r3c5", cap3[3][5], 1'b1);
    chk("dil_pt_k3_r5c7", cap3[5][7], 1'b1);
    chk("dil_pt_k3_r2c5", cap3[2][5], 1'b0);
    chk("dil_pt_k3_r3c8", cap3[3][8], 1'b0);
    chk("dil_pt_k3_r6c7", cap3[6][7], 1'b0);
    chk("dil_pt_k7_r7c11", cap7[7][11], 1'b1);
    chk("dil_pt_k7_r7c12", cap7[7][12], 1'b0);

    // Same image with ~50% clken duty.
    run_frame(1, 1'b1, -1, 2'b00, -1);
    check_frame(1, "dil_gap");

    // Erode, all ones: borders must stay 1.
    fill_img(100);
    run_frame(2, 1'b0, -1, 2'b00, -1);
    check_frame(2, "ero_ones");
    chk("ero_ones_k3_r0c0", cap3[0][0], 1'b1);
    chk("ero_ones_k7_r0c0", cap7[0][0], 1'b1);

    // Erode, single 0 at (4,8).
    img[4][8] = 1'b0;
    run_frame(2, 1'b0, -1, 2'b00, -1);
    check_frame(2, "ero_hole");
    chk("ero_hole_k3_r4c8", cap3[4][8], 1'b0);
    chk("ero_hole_k3_r6c10", cap3[6][10], 1'b0);
    chk("ero_hole_k3_r7c10", cap3[7][10], 1'b1);
    chk("ero_hole_k3_r4c11", cap3[4][11], 1'b1);
    chk("ero_hole_k3_r3c8", cap3[3][8], 1'b1);

    // Dilate, single 1 at (0,0): no wrap into later lines beyond the window.
    fill_img(0); img[0][0] = 1'b1;
    run_frame(1, 1'b0, -1, 2'b00, -1);
    check_frame(1, "dil_org");
    chk("dil_org_k7_r6c6", cap7[6][6], 1'b1);
    chk("dil_org_k7_r0c7", cap7[0][7], 1'b0);
    chk("dil_org_k7_r7c0", cap7[7][0], 1'b0);
    chk("dil_org_k3_r3c0", cap3[3][0], 1'b0);

    // Line-end pixel must not leak into column 0 of the following line.
    fill_img(0); img[2][15] = 1'b1;
    run_frame(1, 1'b0, -1, 2'b00, -1);
    check_frame(1, "dil_eol");
    chk("dil_eol_k3_r3c0", cap3[3][0], 1'b0);

    // Mode changes mid-frame: this frame stays dilate, next frame erodes.
    fill_img(10);
    run_frame(1, 1'b0, 3, 2'b10, -1);
    check_frame(1, "sw_dil");
    fill_img(85);
    run_frame(-1, 1'b0, -1, 2'b00, -1);
    check_frame(2, "sw_ero");

    // Mode 11 and 00 pass the pixel straight through.
    fill_img(50);
    run_frame(3, 1'b1, -1, 2'b00, -1);
    check_frame(3, "byp11");
    fill_img(50);
    run_frame(0, 1'b0, -1, 2'b00, -1);
    check_frame(0, "byp00");

    // Random frames in random modes.
    for (int n = 0; n < 4; n++) begin
      int m;
      m = $urandom_range(0, 3);
      fill_img(m == 2 ? 85 : (m == 1 ? 12 : 50));
      run_frame(m, 1'($urandom_range(0, 1)), -1, 2'b00, -1);
      check_frame(m, $sformatf("rnd%0d_m%0d", n, m));
    end

    // Mid-line reset during an all-ones frame, then a sparse frame must show no stale rows.
    fill_img(100);
    run_frame(1, 1'b0, -1, 2'b00, 3);
    fill_img(0); img[5][10] = 1'b1;
    run_frame(1, 1'b0, -1, 2'b00, -1);
    check_frame(1, "post_rst");
    chk("post_rst_k7_r1c3", cap7[1][3], 1'b0);
    chk("post_rst_k3_r0c10", cap3[0][10], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
